mux_n_to_1_scan: RTL and testbench



---
 rtl/mux_n_to_1_scan.sv | 111 +++++++++++
 tb/tb_mux_n_to_1_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_scan.sv
// Registered N-channel WIDTH-bit channel selector with a valid/ready output
// stage and an automatic round-robin scan mode with per-channel dwell.
module mux_n_to_1_scan #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] I,
    input  logic [SW-1:0]      S,
    input  logic               M,
    input  logic               EN,
    input  logic               RDY,
    output logic [WIDTH-1:0]   Y,
    output logic [SW-1:0]      CH,
    output logic               V
);

    localparam int NP = 1 << SW;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW:0]   N_WIDE = (SW + 1)'(N);
    localparam logic [SW-1:0] P_LAST = SW'(N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

    logic [WIDTH-1:0] y_reg, y_next;
    logic [SW-1:0]    ch_reg, ch_next;
    logic             v_reg, v_next;
    logic [SW-1:0]    ptr_reg, ptr_next;
    logic [DW-1:0]    dcnt_reg, dcnt_next;

    logic             load;
    logic             sel_ok;

    // Channels padded to a power of two so any select index reads a defined value.
    logic [WIDTH-1:0] chan [NP];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_chan
            if (gi < N) begin : g_live
                assign chan[gi] = I[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    assign load   = !v_reg || RDY;
    assign sel_ok = ({1'b0, S} < N_WIDE);

    always_comb begin
        y_next    = y_reg;
        ch_next   = ch_reg;
        v_next    = v_reg;
        ptr_next  = ptr_reg;
        dcnt_next = dcnt_reg;

        // Direct mode keeps the scan parked at channel 0, even while stalled.
        if (!M) begin
            ptr_next  = '0;
            dcnt_next = '0;
        end

        if (load) begin
            if (!EN) begin
                v_next = 1'b0;
            end else if (!M) begin
                if (sel_ok) begin
                    y_next  = chan[S];
                    ch_next = S;
                    v_next  = 1'b1;
                end else begin
                    v_next = 1'b0;
                end
            end else begin
                y_next  = chan[ptr_reg];
                ch_next = ptr_reg;
                v_next  = 1'b1;
                if (dcnt_reg == D_LAST) begin
                    dcnt_next = '0;
                    ptr_next  = (ptr_reg == P_LAST) ? '0 : SW'(ptr_reg + 1'b1);
                end else begin
                    dcnt_next = DW'(dcnt_reg + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg    <= '0;
            ch_reg   <= '0;
            v_reg    <= 1'b0;
            ptr_reg  <= '0;
            dcnt_reg <= '0;
        end else begin
            y_reg    <= y_next;
            ch_reg   <= ch_next;
            v_reg    <= v_next;
            ptr_reg  <= ptr_next;
            dcnt_reg <= dcnt_next;
        end
    end

    assign Y  = y_reg;
    assign CH = ch_reg;
    assign V  = v_reg;

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Directed bench for mux_n_to_1_scan: three instances (8ch, 5ch dwell 1,
// 5ch dwell 3) sharing clock and reset, checked with immediate assertions.
module tb_mux_n_to_1_scan;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8 channels, dwell 1
    logic [63:0] i8;
    logic [2:0]  s8, ch8;
    logic        m8, en8, rdy8, v8;
    logic [7:0]  y8;

    // 5 channels, dwell 1
    logic [39:0] ia;
    logic [2:0]  sa, cha;
    logic        ma, ena, rdya, va;
    logic [7:0]  ya;

    // 5 channels, dwell 3
    logic [39:0] ib;
    logic [2:0]  sb, chb;
    logic        mb, enb, rdyb, vb;
    logic [7:0]  yb;

    mux_n_to_1_scan #(.WIDTH(8), .N(8), .DWELL(1)) u8 (
        .clk(clk), .rst(rst), .I(i8), .S(s8), .M(m8), .EN(en8), .RDY(rdy8),
        .Y(y8), .CH(ch8), .V(v8)
    );
    mux_n_to_1_scan #(.WIDTH(8), .N(5), .DWELL(1)) ua (
        .clk(clk), .rst(rst), .I(ia), .S(sa), .M(ma), .EN(ena), .RDY(rdya),
        .Y(ya), .CH(cha), .V(va)
    );
    mux_n_to_1_scan #(.WIDTH(8), .N(5), .DWELL(3)) ub (
        .clk(clk), .rst(rst), .I(ib), .S(sb), .M(mb), .EN(enb), .RDY(rdyb),
        .Y(yb), .CH(chb), .V(vb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s8 = 0; m8 = 0; en8 = 0; rdy8 = 1;
        sa = 0; ma = 0; ena = 0; rdya = 1;
        sb = 0; mb = 0; enb = 0; rdyb = 1;
        for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'(32'h10 + k);
        for (int k = 0; k < 5; k++) ia[k*8 +: 8] = 8'(32'h20 + k);
        for (int k = 0; k < 5; k++) ib[k*8 +: 8] = 8'(32'h30 + k);

        // Reset state over two cycles
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_y", y8, 0);
            chk("rst_v", v8, 0);
            $display("reset cycle %0d: Y=%0h CH=%0d V=%0b", c, y8, ch8, v8);
        end
        chk("rst_ch", ch8, 0);

        // Direct mode, S=5
        rst = 1'b0; m8 = 0; en8 = 1; rdy8 = 1; s8 = 3'd5;
        tick();
        chk("dir_s5_y", y8, 8'h15);
        chk("dir_s5_ch", ch8, 5);
        chk("dir_s5_v", v8, 1);
        $display("direct S=5: Y=%0h CH=%0d V=%0b", y8, ch8, v8);

        // Direct sweep S=0..7
        for (int s = 0; s < 8; s++) begin
            s8 = 3'(s);
            tick();
            chk("dir_sweep_y", y8, 32'h10 + s);
            chk("dir_sweep_ch", ch8, s);
            $display("direct S=%0d: Y=%0h CH=%0d V=%0b", s, y8, ch8, v8);
        end
        en8 = 0;
        tick();
        chk("dir_en0_v", v8, 0);
        chk("dir_en0_y", y8, 8'h17);
        $display("direct EN=0: Y=%0h CH=%0d V=%0b", y8, ch8, v8);

        // Scan with wrap, N=5 DWELL=1
        ma = 1; ena = 1; rdya = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("scan_ch", cha, k % 5);
            chk("scan_y", ya, 32'h20 + (k % 5));
            chk("scan_v", va, 1);
            $display("scan beat %0d: Y=%0h CH=%0d V=%0b", k, ya, cha, va);
        end

        // Backpressure at CH=2 with I changing underneath
        tick();
        chk("bp_load_ch", cha, 2);
        rdya = 0;
        for (int c = 0; c < 4; c++) begin
            ia[2*8 +: 8] = 8'(32'hA0 + c);
            tick();
            chk("bp_stall_ch", cha, 2);
            chk("bp_stall_y", ya, 8'h22);
            chk("bp_stall_v", va, 1);
            $display("stall %0d: Y=%0h CH=%0d V=%0b", c, ya, cha, va);
        end
        ia[2*8 +: 8] = 8'h22;
        rdya = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_resume_ch", cha, (3 + k) % 5);
            chk("bp_resume_y", ya, 32'h20 + ((3 + k) % 5));
            $display("resume beat %0d: Y=%0h CH=%0d V=%0b", k, ya, cha, va);
        end

        // Continue scan to CH=3, then one direct beat S=1, then scan restarts at 0
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pre_switch_ch", cha, 1 + k);
        end
        ma = 0; sa = 3'd1;
        tick();
        chk("switch_dir_ch", cha, 1);
        chk("switch_dir_y", ya, 8'h21);
        $display("mode switch direct: Y=%0h CH=%0d V=%0b", ya, cha, va);
        ma = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("switch_scan_ch", cha, k);
            chk("switch_scan_y", ya, 32'h20 + k);
            $display("rescan beat %0d: Y=%0h CH=%0d V=%0b", k, ya, cha, va);
        end

        // EN gap: V drops, pointer holds
        ena = 0;
        tick();
        chk("engap_v", va, 0);
        chk("engap_ch", cha, 2);
        chk("engap_y", ya, 8'h22);
        $display("EN gap: Y=%0h CH=%0d V=%0b", ya, cha, va);
        ena = 1;
        tick();
        chk("engap_resume_ch", cha, 3);
        chk("engap_resume_v", va, 1);
        $display("EN resume: Y=%0h CH=%0d V=%0b", ya, cha, va);

        // Illegal select S=6 on N=5
        ma = 0; sa = 3'd6;
        tick();
        chk("illegal_v", va, 0);
        chk("illegal_y", ya, 8'h23);
        chk("illegal_ch", cha, 3);
        $display("illegal S=6: Y=%0h CH=%0d V=%0b", ya, cha, va);
        sa = 3'd4;
        tick();
        chk("legal_s4_v", va, 1);
        chk("legal_s4_ch", cha, 4);
        chk("legal_s4_y", ya, 8'h24);
        $display("direct S=4: Y=%0h CH=%0d V=%0b", ya, cha, va);

        // Dwell of 3 with wrap
        mb = 1; enb = 1; rdyb = 1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("dwell3_ch", chb, (k / 3) % 5);
            chk("dwell3_y", yb, 32'h30 + ((k / 3) % 5));
            $display("dwell3 beat %0d: Y=%0h CH=%0d V=%0b", k, yb, chb, vb);
        end
        enb = 0;

        // Reset during a stall at CH=3
        ma = 1; ena = 1; rdya = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("prerst_ch", cha, k);
        end
        rdya = 0;
        tick();
        chk("prerst_stall_ch", cha, 3);
        chk("prerst_stall_v", va, 1);
        rst = 1;
        tick();
        chk("midrst_v", va, 0);
        chk("midrst_y", ya, 0);
        chk("midrst_ch", cha, 0);
        $display("mid reset: Y=%0h CH=%0d V=%0b", ya, cha, va);
        rst = 0; rdya = 1;
        tick();
        chk("postrst_ch", cha, 0);
        chk("postrst_y", ya, 8'h20);
        chk("postrst_v", va, 1);
        $display("post reset beat: Y=%0h CH=%0d V=%0b", ya, cha, va);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
